// File: rtl/exec_stage.sv
// Execute stage of the 5-stage RV32I pipeline: forwarding, ALU, branch/jump
// resolution and the EX/MEM pipeline register.
// Optional feature: define EX_MUL_EN to add an iterative shift-add multiplier
// (ALUControl = 4'hB) that stalls the stage while it works.
module exec_stage #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            EN,
  input  logic            Flush,
  input  logic [XLEN-1:0] R_1,
  input  logic [XLEN-1:0] R_2,
  input  logic [4:0]      R_1_num,
  input  logic [4:0]      R_2_num,
  input  logic [4:0]      DR_num,
  input  logic [XLEN-1:0] ImmExt,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] PC_plus_4,
  input  logic [1:0]      ResultSrc,
  input  logic            MemWrite,
  input  logic            MemRead,
  input  logic            RegWrite,
  input  logic            ALUSrc,
  input  logic            Jump,
  input  logic            Branch,
  input  logic            JumpReg,
  input  logic [2:0]      funct3,
  input  logic [3:0]      ALUControl,
  input  logic [1:0]      ForwardA,
  input  logic [1:0]      ForwardB,
  input  logic [XLEN-1:0] WB_Result,
  input  logic [XLEN-1:0] MEM_ALUResult,
  output logic            PCSrc,
  output logic [XLEN-1:0] PCTarget,
  output logic            Stall,
  output logic [XLEN-1:0] ALUResult,
  output logic [XLEN-1:0] WriteData,
  output logic [XLEN-1:0] PC_plus_4_M,
  output logic [4:0]      DR_num_M,
  output logic [1:0]      ResultSrc_M,
  output logic            RegWrite_M,
  output logic            MemWrite_M,
  output logic            MemRead_M
);

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] wd;
    logic [XLEN-1:0] pc4;
    logic [4:0]      dr;
    logic [1:0]      rs;
    logic            rw;
    logic            mw;
    logic            mr;
  } exMem_t;

  logic [XLEN-1:0] fwdA, fwdB, srcA, srcB, aluOut;
  logic [XLEN-1:0] mulResult;
  logic            mulDone;
  logic            branchCond;
  exMem_t          exMem_d, exMem_q;

  // Register numbers are only consumed by the hazard unit, not here.
  logic unusedRegNums;
  assign unusedRegNums = ^{R_1_num, R_2_num};

  // Forwarding muxes select the freshest copy of each source operand.
  always_comb begin
    fwdA = R_1;
    fwdB = R_2;
    case (ForwardA)
      2'b01:   fwdA = WB_Result;
      2'b10:   fwdA = MEM_ALUResult;
      default: fwdA = R_1;
    endcase
    case (ForwardB)
      2'b01:   fwdB = WB_Result;
      2'b10:   fwdB = MEM_ALUResult;
      default: fwdB = R_2;
    endcase
  end

  assign srcA = fwdA;
  assign srcB = ALUSrc ? ImmExt : fwdB;

  // Single-cycle ALU; MUL is produced by the iterative unit, so it reads 0 here.
  always_comb begin
    aluOut = '0;
    case (ALUControl)
      4'h0:    aluOut = srcA + srcB;
      4'h1:    aluOut = srcA - srcB;
      4'h2:    aluOut = srcA & srcB;
      4'h3:    aluOut = srcA | srcB;
      4'h4:    aluOut = srcA ^ srcB;
      4'h5:    aluOut = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      4'h6:    aluOut = {{(XLEN-1){1'b0}}, (srcA < srcB)};
      4'h7:    aluOut = srcA << srcB[4:0];
      4'h8:    aluOut = srcA >> srcB[4:0];
      4'h9:    aluOut = XLEN'($signed(srcA) >>> srcB[4:0]);
      4'hA:    aluOut = srcB;
      default: aluOut = '0;
    endcase
  end

  // Branch comparator always works on the forwarded registers, never the immediate.
  always_comb begin
    branchCond = 1'b0;
    case (funct3)
      3'b000:  branchCond = (fwdA == fwdB);
      3'b001:  branchCond = (fwdA != fwdB);
      3'b100:  branchCond = ($signed(fwdA) < $signed(fwdB));
      3'b101:  branchCond = ($signed(fwdA) >= $signed(fwdB));
      3'b110:  branchCond = (fwdA < fwdB);
      3'b111:  branchCond = (fwdA >= fwdB);
      default: branchCond = 1'b0;
    endcase
  end

  assign PCSrc    = Jump | (Branch & branchCond);
  assign PCTarget = JumpReg ? ((fwdA + ImmExt) & ~XLEN'(1)) : (PC + ImmExt);

`ifdef EX_MUL_EN
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mulState_t;

  mulState_t       mulState_q;
  logic [XLEN-1:0] mcand_q, mplier_q, acc_q;
  logic [CW-1:0]   cnt_q;
  logic            isMul;

  assign isMul     = (ALUControl == 4'hB);
  assign Stall     = (mulState_q == BUSY) | ((mulState_q == IDLE) & EN & isMul);
  assign mulDone   = (mulState_q == DONE);
  assign mulResult = acc_q;

  // Multiplier sequencer: latch operands, one shift-add per enabled cycle, then hand off.
  always_ff @(posedge clk) begin
    if (reset) begin
      mulState_q <= IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else if (Flush) begin
      mulState_q <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else if (EN) begin
      case (mulState_q)
        IDLE: begin
          if (isMul) begin
            mcand_q    <= srcA;
            mplier_q   <= srcB;
            acc_q      <= '0;
            cnt_q      <= '0;
            mulState_q <= BUSY;
          end
        end
        BUSY: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(MUL_LAT - 1)) mulState_q <= DONE;
        end
        DONE:    mulState_q <= IDLE;
        default: mulState_q <= IDLE;
      endcase
    end
  end
`else
  localparam int unusedMulLat = MUL_LAT;
  assign Stall     = 1'b0;
  assign mulDone   = 1'b0;
  assign mulResult = '0;
`endif

  // EX/MEM next state: flush beats enable, a stall inserts a bubble.
  always_comb begin
    exMem_d = exMem_q;
    if (Flush) begin
      exMem_d = '0;
    end else if (EN) begin
      if (Stall) begin
        exMem_d = '0;
      end else begin
        exMem_d.alu = mulDone ? mulResult : aluOut;
        exMem_d.wd  = fwdB;
        exMem_d.pc4 = PC_plus_4;
        exMem_d.dr  = DR_num;
        exMem_d.rs  = ResultSrc;
        exMem_d.rw  = RegWrite;
        exMem_d.mw  = MemWrite;
        exMem_d.mr  = MemRead;
      end
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk) begin
    if (reset) exMem_q <= '0;
    else       exMem_q <= exMem_d;
  end

  assign ALUResult   = exMem_q.alu;
  assign WriteData   = exMem_q.wd;
  assign PC_plus_4_M = exMem_q.pc4;
  assign DR_num_M    = exMem_q.dr;
  assign ResultSrc_M = exMem_q.rs;
  assign RegWrite_M  = exMem_q.rw;
  assign MemWrite_M  = exMem_q.mw;
  assign MemRead_M   = exMem_q.mr;

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed cases with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_exec_stage;

  localparam int MUL_LAT = 32;

  logic        clk;
  logic        reset, EN, Flush;
  logic [31:0] R_1, R_2, ImmExt, PC, PC_plus_4, WB_Result, MEM_ALUResult;
  logic [4:0]  R_1_num, R_2_num, DR_num;
  logic [1:0]  ResultSrc, ForwardA, ForwardB;
  logic        MemWrite, MemRead, RegWrite, ALUSrc, Jump, Branch, JumpReg;
  logic [2:0]  funct3;
  logic [3:0]  ALUControl;
  logic        PCSrc, Stall;
  logic [31:0] PCTarget, ALUResult, WriteData, PC_plus_4_M;
  logic [4:0]  DR_num_M;
  logic [1:0]  ResultSrc_M;
  logic        RegWrite_M, MemWrite_M, MemRead_M;

  int compared;
  int mismatched;
  bit modelOn;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [4:0]  dr;
    logic [1:0]  rs;
    logic [2:0]  ctl;
  } expect_t;

  expect_t     expQ;
  expect_t     expNext;
  logic [31:0] mA, mB, mSrcB, cA, cB, cTarget;
  logic        cPcSrc;

  exec_stage #(.XLEN(32), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .EN(EN), .Flush(Flush),
    .R_1(R_1), .R_2(R_2), .R_1_num(R_1_num), .R_2_num(R_2_num), .DR_num(DR_num),
    .ImmExt(ImmExt), .PC(PC), .PC_plus_4(PC_plus_4), .ResultSrc(ResultSrc),
    .MemWrite(MemWrite), .MemRead(MemRead), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .Jump(Jump), .Branch(Branch), .JumpReg(JumpReg), .funct3(funct3),
    .ALUControl(ALUControl), .ForwardA(ForwardA), .ForwardB(ForwardB),
    .WB_Result(WB_Result), .MEM_ALUResult(MEM_ALUResult),
    .PCSrc(PCSrc), .PCTarget(PCTarget), .Stall(Stall),
    .ALUResult(ALUResult), .WriteData(WriteData), .PC_plus_4_M(PC_plus_4_M),
    .DR_num_M(DR_num_M), .ResultSrc_M(ResultSrc_M),
    .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M), .MemRead_M(MemRead_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Forwarding source as the architecture defines it.
  function automatic logic [31:0] pickFwd(input logic [1:0] sel, input logic [31:0] r,
                                          input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'b01) return wb;
    if (sel == 2'b10) return mem;
    return r;
  endfunction

  // ALU reference written with plain arithmetic identities.
  function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    int unsigned sh;
    logic [63:0] wide;
    sh = b[4:0];
    case (op)
      4'h0: return a + b;
      4'h1: return a + ~b + 32'd1;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      4'h6: return {31'd0, (a < b)};
      4'h7: begin wide = {32'd0, a} * (64'd1 << sh); return wide[31:0]; end
      4'h8: return a / (32'd1 << sh);
      4'h9: return a[31] ? ~((~a) / (32'd1 << sh)) : a / (32'd1 << sh);
      4'hA: return b;
      default: return 32'd0;
    endcase
  endfunction

  // Branch decision reference.
  function automatic logic refTaken(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    logic signedLess;
    signedLess = (a[31] != b[31]) ? a[31] : (a < b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return signedLess;
      3'b101:  return !signedLess;
      3'b110:  return a < b;
      3'b111:  return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic setNop;
    reset = 0; EN = 1; Flush = 0;
    R_1 = 0; R_2 = 0; R_1_num = 0; R_2_num = 0; DR_num = 0;
    ImmExt = 0; PC = 0; PC_plus_4 = 0; ResultSrc = 0;
    MemWrite = 0; MemRead = 0; RegWrite = 0; ALUSrc = 0;
    Jump = 0; Branch = 0; JumpReg = 0; funct3 = 0; ALUControl = 0;
    ForwardA = 0; ForwardB = 0; WB_Result = 0; MEM_ALUResult = 0;
  endtask

  // One cycle of random traffic (MUL excluded when the multiplier is built).
  task automatic applyStimulus;
    int maxOp;
`ifdef EX_MUL_EN
    maxOp = 10;
`else
    maxOp = 11;
`endif
    stepCycle;
    reset         = ($urandom_range(0, 59) == 0);
    Flush         = ($urandom_range(0, 11) == 0);
    EN            = ($urandom_range(0, 7) != 0);
    R_1           = $urandom;
    R_2           = ($urandom_range(0, 3) == 0) ? R_1 : $urandom;
    ImmExt        = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
    WB_Result     = $urandom;
    MEM_ALUResult = $urandom;
    PC            = $urandom & 32'hFFFF_FFFC;
    PC_plus_4     = PC + 32'd4;
    R_1_num       = 5'($urandom);
    R_2_num       = 5'($urandom);
    DR_num        = 5'($urandom);
    ResultSrc     = 2'($urandom);
    ForwardA      = 2'($urandom);
    ForwardB      = 2'($urandom);
    MemWrite      = 1'($urandom);
    MemRead       = 1'($urandom);
    RegWrite      = 1'($urandom);
    ALUSrc        = 1'($urandom);
    Branch        = 1'($urandom);
    Jump          = ($urandom_range(0, 5) == 0);
    JumpReg       = 1'($urandom);
    funct3        = 3'($urandom);
    ALUControl    = 4'($urandom_range(0, maxOp));
  endtask

  // Model of the EX/MEM register, advanced on every clock edge.
  always @(posedge clk) begin
    mA             = pickFwd(ForwardA, R_1, WB_Result, MEM_ALUResult);
    mB             = pickFwd(ForwardB, R_2, WB_Result, MEM_ALUResult);
    mSrcB          = ALUSrc ? ImmExt : mB;
    expNext.alu    = refAlu(ALUControl, mA, mSrcB);
    expNext.wd     = mB;
    expNext.pc4    = PC_plus_4;
    expNext.dr     = DR_num;
    expNext.rs     = ResultSrc;
    expNext.ctl    = {RegWrite, MemWrite, MemRead};
    if (reset || Flush) expQ <= '0;
    else if (EN)        expQ <= expNext;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (modelOn) begin
      cA      = pickFwd(ForwardA, R_1, WB_Result, MEM_ALUResult);
      cB      = pickFwd(ForwardB, R_2, WB_Result, MEM_ALUResult);
      cPcSrc  = Jump | (Branch & refTaken(funct3, cA, cB));
      cTarget = JumpReg ? ((cA + ImmExt) & 32'hFFFF_FFFE) : (PC + ImmExt);
      checkOutput("PCSrc", {31'd0, PCSrc}, {31'd0, cPcSrc});
      checkOutput("PCTarget", PCTarget, cTarget);
      checkOutput("Stall", {31'd0, Stall}, 32'd0);
      checkOutput("ALUResult", ALUResult, expQ.alu);
      checkOutput("WriteData", WriteData, expQ.wd);
      checkOutput("PC_plus_4_M", PC_plus_4_M, expQ.pc4);
      checkOutput("DR_num_M", {27'd0, DR_num_M}, {27'd0, expQ.dr});
      checkOutput("ResultSrc_M", {30'd0, ResultSrc_M}, {30'd0, expQ.rs});
      checkOutput("ctl_M", {29'd0, RegWrite_M, MemWrite_M, MemRead_M}, {29'd0, expQ.ctl});
    end
  end

`ifdef EX_MUL_EN
  // Runs one MUL to completion, checking stall length and the delivered product.
  task automatic runMul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] prod);
    int stallCycles;
    bit dropped;
    setNop;
    R_1 = a; R_2 = b; ALUControl = 4'hB; DR_num = 5'd7; RegWrite = 1;
    stallCycles = 0;
    dropped     = 0;
    for (int c = 0; c < 200; c++) begin
      #2;
      if (Stall !== 1'b1) begin
        dropped = 1;
        break;
      end
      stallCycles++;
      stepCycle;
      if (c == 0) checkOutput("mul_bubble", {31'd0, RegWrite_M}, 32'd0);
    end
    checkOutput("mul_stall_drop", {31'd0, dropped}, 32'd1);
    checkOutput("mul_stall_cycles", stallCycles, MUL_LAT + 1);
    stepCycle;
    checkOutput("mul_result", ALUResult, prod);
    checkOutput("mul_dr", {27'd0, DR_num_M}, 32'd7);
    checkOutput("mul_regwrite", {31'd0, RegWrite_M}, 32'd1);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    modelOn    = 0;
    setNop;
    reset = 1;
    repeat (2) stepCycle;
    checkOutput("reset_alu", ALUResult, 32'd0);
    checkOutput("reset_regwrite", {31'd0, RegWrite_M}, 32'd0);
    checkOutput("reset_dr", {27'd0, DR_num_M}, 32'd0);
    checkOutput("reset_pcsrc", {31'd0, PCSrc}, 32'd0);
    checkOutput("reset_stall", {31'd0, Stall}, 32'd0);
    reset   = 0;
    modelOn = 1;

    setNop;
    R_1 = 5; R_2 = 7; DR_num = 5'd9; RegWrite = 1; ResultSrc = 2'b01; PC_plus_4 = 32'h24;
    stepCycle;
    checkOutput("add_result", ALUResult, 32'd12);
    checkOutput("add_dr", {27'd0, DR_num_M}, 32'd9);
    checkOutput("add_regwrite", {31'd0, RegWrite_M}, 32'd1);
    checkOutput("add_pc4", PC_plus_4_M, 32'h24);

    setNop;
    ForwardA = 2'b10; MEM_ALUResult = 32'h100; R_1 = 32'hDEAD; ALUSrc = 1;
    ImmExt = 32'hFFFF_FFFC; R_2 = 32'h55;
    stepCycle;
    checkOutput("fwd_imm_result", ALUResult, 32'hFC);
    checkOutput("fwd_writedata", WriteData, 32'h55);

    setNop;
    Branch = 1; funct3 = 3'b000; PC = 32'h40; ImmExt = 32'h10; R_1 = 9; R_2 = 9;
    #2;
    checkOutput("beq_taken", {31'd0, PCSrc}, 32'd1);
    checkOutput("beq_target", PCTarget, 32'h50);
    R_2 = 8;
    #1;
    checkOutput("beq_not_taken", {31'd0, PCSrc}, 32'd0);
    stepCycle;

    setNop;
    Jump = 1; JumpReg = 1; R_1 = 32'h1001; ImmExt = 2; RegWrite = 1; Flush = 1;
    #2;
    checkOutput("jalr_target", PCTarget, 32'h1002);
    checkOutput("jalr_pcsrc", {31'd0, PCSrc}, 32'd1);
    stepCycle;
    checkOutput("flush_regwrite", {31'd0, RegWrite_M}, 32'd0);
    checkOutput("flush_alu", ALUResult, 32'd0);

    setNop;
    R_1 = 32'h8000_0000; ALUSrc = 1; ImmExt = 31; ALUControl = 4'h9;
    stepCycle;
    checkOutput("sra_result", ALUResult, 32'hFFFF_FFFF);
    setNop;
    R_1 = 1; R_2 = 32'hFFFF_FFFF; ALUControl = 4'h6;
    stepCycle;
    checkOutput("sltu_result", ALUResult, 32'd1);
    setNop;
    R_1 = 1; R_2 = 32'hFFFF_FFFF; ALUControl = 4'h5;
    stepCycle;
    checkOutput("slt_result", ALUResult, 32'd0);

    setNop;
    R_1 = 3; R_2 = 4;
    stepCycle;
    setNop;
    EN = 0; R_1 = 100; R_2 = 1;
    stepCycle;
    checkOutput("hold_result", ALUResult, 32'd7);

`ifdef EX_MUL_EN
    modelOn = 0;
    runMul(32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF);
    runMul(32'd3, 32'd5, 32'd15);
    setNop;
    R_1 = 32'h1234; R_2 = 32'h5678; ALUControl = 4'hB; RegWrite = 1;
    repeat (10) stepCycle;
    Flush = 1;
    #2;
    checkOutput("mul_busy_before_flush", {31'd0, Stall}, 32'd1);
    stepCycle;
    setNop;
    #2;
    checkOutput("mul_flush_stall", {31'd0, Stall}, 32'd0);
    checkOutput("mul_flush_regwrite", {31'd0, RegWrite_M}, 32'd0);
    stepCycle;
    setNop;
    reset = 1;
    stepCycle;
    reset   = 0;
    modelOn = 1;
`else
    setNop;
    R_1 = 3; R_2 = 5; ALUControl = 4'hB; RegWrite = 1;
    #2;
    checkOutput("nomul_stall", {31'd0, Stall}, 32'd0);
    stepCycle;
    checkOutput("nomul_result", ALUResult, 32'd0);
`endif

    repeat (600) applyStimulus;
    stepCycle;
    setNop;
    stepCycle;
    modelOn = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
